// File: rtl/window_counter_pkg.sv
// Shared types and constants for the window event counter.
package window_counter_pkg;

   typedef enum logic [1:0] {
      ALIGN = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } wc_state_t;

   localparam int EDGE_LEVEL = 0;
   localparam int EDGE_RISE  = 1;

endpackage

// File: rtl/window_event_counter_rise_detect.sv
// Rising-edge detector: registered history, pulse is high for the first cycle the input is high.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pulse
);

   logic in_q;
   logic in_d;

   always_comb in_d = in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) in_q <= 1'b0;
      else      in_q <= in_d;
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/window_event_counter.sv
// Counts qualified events between markers: SKIP_MARKS markers align the count, the next one
// closes the window and captures the result until acknowledged with rst_done.
module window_event_counter
   import window_counter_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int SKIP_MARKS = 1,
   parameter int EDGE_MODE  = EDGE_LEVEL,
   parameter int SATURATE   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mark,
   input  logic             cnt_up,
   input  logic             rst_done,
   input  logic             soft_clr,
   output logic             done,
   output logic             ovf,
   output logic [WIDTH-1:0] cout,
   output logic [WIDTH-1:0] result
);

   localparam wc_state_t RESET_STATE = (SKIP_MARKS > 0) ? ALIGN : COUNT;

   wc_state_t        state_q, state_d;
   logic [WIDTH-1:0] cout_q, cout_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic             ev;
   logic             inc_hit;
   logic [WIDTH-1:0] inc_val;
   logic             align_last;

   generate
      if (EDGE_MODE == EDGE_RISE) begin : g_rise
         rise_detect u_rise (
            .clk   (clk),
            .rst   (rst),
            .in    (cnt_up),
            .pulse (ev)
         );
      end else begin : g_level
         assign ev = cnt_up;
      end
   endgenerate

   // align_last is high when the marker arriving now is the final aligning one.
   generate
      if (SKIP_MARKS > 0) begin : g_skip
         localparam int MC_W = $clog2(SKIP_MARKS + 1);
         logic [MC_W-1:0] mark_cnt_q, mark_cnt_d;
         logic            mark_step;

         assign mark_step  = (state_q == ALIGN) & mark & ~soft_clr;
         assign align_last = (mark_cnt_q == MC_W'(SKIP_MARKS - 1));

         always_comb begin
            mark_cnt_d = mark_cnt_q;
            if (soft_clr)       mark_cnt_d = '0;
            else if (mark_step) mark_cnt_d = mark_cnt_q + MC_W'(1);
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) mark_cnt_q <= '0;
            else      mark_cnt_q <= mark_cnt_d;
         end
      end else begin : g_noskip
         assign align_last = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= RESET_STATE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (soft_clr) begin
         state_d = RESET_STATE;
      end else begin
         case (state_q)
            ALIGN:   if (mark && align_last) state_d = COUNT;
            COUNT:   if (mark) state_d = DONE;
            DONE:    if (rst_done) state_d = COUNT;
            default: state_d = RESET_STATE;
         endcase
      end
   end

   // inc_val is cout plus the current event, already folded through the overflow rule.
   always_comb begin
      inc_hit  = ev & (&cout_q);
      inc_val  = cout_q + {{(WIDTH-1){1'b0}}, ev};
      if (inc_hit) inc_val = (SATURATE != 0) ? cout_q : '0;

      cout_d   = cout_q;
      result_d = result_q;
      done_d   = done_q;
      ovf_d    = ovf_q;

      if (soft_clr) begin
         cout_d   = '0;
         result_d = '0;
         done_d   = 1'b0;
         ovf_d    = 1'b0;
      end else begin
         case (state_q)
            ALIGN: begin
               if (mark) begin
                  cout_d = '0;
                  ovf_d  = 1'b0;
               end else if (ev) begin
                  cout_d = inc_val;
                  ovf_d  = ovf_q | inc_hit;
               end
            end
            COUNT: begin
               if (mark) begin
                  result_d = inc_val;
                  ovf_d    = ovf_q | inc_hit;
                  cout_d   = '0;
                  done_d   = 1'b1;
               end else if (ev) begin
                  cout_d = inc_val;
                  ovf_d  = ovf_q | inc_hit;
               end
            end
            DONE: begin
               cout_d = '0;
               if (rst_done) begin
                  done_d = 1'b0;
                  ovf_d  = 1'b0;
               end
            end
            default: begin
               cout_d = '0;
               done_d = 1'b0;
               ovf_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cout_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         cout_q   <= cout_d;
         result_q <= result_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   assign cout   = cout_q;
   assign result = result_q;
   assign done   = done_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_window_event_counter.sv
// Drives four differently parameterised counters with shared stimulus and checks them against
// an unbounded-integer window model plus a queue of expected closed-window results.
module tb_window_event_counter;

   localparam int N = 4;

   logic clk;
   logic rst;
   logic mark;
   logic cnt_up;
   logic rst_done;
   logic soft_clr;

   logic        done_w [N];
   logic        ovf_w  [N];
   logic [15:0] cout0, result0;
   logic [3:0]  cout1, result1;
   logic [3:0]  cout2, result2;
   logic [7:0]  cout3, result3;

   logic [63:0] a_cout [N];
   logic [63:0] a_res  [N];

   assign a_cout[0] = 64'(cout0);
   assign a_cout[1] = 64'(cout1);
   assign a_cout[2] = 64'(cout2);
   assign a_cout[3] = 64'(cout3);
   assign a_res[0]  = 64'(result0);
   assign a_res[1]  = 64'(result1);
   assign a_res[2]  = 64'(result2);
   assign a_res[3]  = 64'(result3);

   window_event_counter #(.WIDTH(16), .SKIP_MARKS(1), .EDGE_MODE(0), .SATURATE(1)) dut0 (
      .clk(clk), .rst(rst), .mark(mark), .cnt_up(cnt_up), .rst_done(rst_done),
      .soft_clr(soft_clr), .done(done_w[0]), .ovf(ovf_w[0]), .cout(cout0), .result(result0));
   window_event_counter #(.WIDTH(4), .SKIP_MARKS(1), .EDGE_MODE(0), .SATURATE(1)) dut1 (
      .clk(clk), .rst(rst), .mark(mark), .cnt_up(cnt_up), .rst_done(rst_done),
      .soft_clr(soft_clr), .done(done_w[1]), .ovf(ovf_w[1]), .cout(cout1), .result(result1));
   window_event_counter #(.WIDTH(4), .SKIP_MARKS(2), .EDGE_MODE(0), .SATURATE(0)) dut2 (
      .clk(clk), .rst(rst), .mark(mark), .cnt_up(cnt_up), .rst_done(rst_done),
      .soft_clr(soft_clr), .done(done_w[2]), .ovf(ovf_w[2]), .cout(cout2), .result(result2));
   window_event_counter #(.WIDTH(8), .SKIP_MARKS(0), .EDGE_MODE(1), .SATURATE(1)) dut3 (
      .clk(clk), .rst(rst), .mark(mark), .cnt_up(cnt_up), .rst_done(rst_done),
      .soft_clr(soft_clr), .done(done_w[3]), .ovf(ovf_w[3]), .cout(cout3), .result(result3));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d @%0t", nm, act, req, $time);
      end
   endtask

   function automatic int cfg_w(int k);
      case (k) 0: return 16; 1: return 4; 2: return 4; default: return 8; endcase
   endfunction
   function automatic int cfg_skip(int k);
      case (k) 0: return 1; 1: return 1; 2: return 2; default: return 0; endcase
   endfunction
   function automatic bit cfg_edge(int k);
      return (k == 3);
   endfunction
   function automatic bit cfg_sat(int k);
      return (k != 2);
   endfunction

   // ---------------- reference model ----------------
   // phase: 0 aligning, 1 measuring, 2 closed. cnt is an unbounded event tally; the visible
   // counter and overflow flag are derived from it by saturation or modulo.
   int    m_phase [N];
   int    m_marks [N];
   longint m_cnt  [N];
   longint m_res  [N];
   bit    m_ovfd  [N];
   bit    m_prev;
   logic [16:0] exp_q [N][$];

   function automatic longint max_of(int k);
      return (longint'(1) << cfg_w(k)) - 1;
   endfunction

   function automatic longint view(int k, longint t);
      if (cfg_sat(k)) return (t > max_of(k)) ? max_of(k) : t;
      return t % (max_of(k) + 1);
   endfunction

   function automatic void model_restart(int k);
      m_phase[k] = (cfg_skip(k) > 0) ? 0 : 1;
      m_marks[k] = 0;
      m_cnt[k]   = 0;
      m_res[k]   = 0;
      m_ovfd[k]  = 1'b0;
   endfunction

   function automatic void model_hard_reset();
      for (int k = 0; k < N; k++) model_restart(k);
      m_prev = 1'b0;
   endfunction

   function automatic void model_clock();
      bit ev;
      longint tot;
      for (int k = 0; k < N; k++) begin
         ev = cfg_edge(k) ? (cnt_up && !m_prev) : cnt_up;
         if (soft_clr) begin
            model_restart(k);
         end else if (m_phase[k] == 0) begin
            if (mark) begin
               m_cnt[k] = 0;
               m_marks[k]++;
               if (m_marks[k] == cfg_skip(k)) m_phase[k] = 1;
            end else if (ev) m_cnt[k]++;
         end else if (m_phase[k] == 1) begin
            if (mark) begin
               tot       = m_cnt[k] + (ev ? 1 : 0);
               m_res[k]  = view(k, tot);
               m_ovfd[k] = (tot > max_of(k));
               m_cnt[k]  = 0;
               m_phase[k] = 2;
               exp_q[k].push_back({m_ovfd[k], 16'(m_res[k])});
            end else if (ev) m_cnt[k]++;
         end else begin
            if (rst_done) m_phase[k] = 1;
         end
      end
      m_prev = cnt_up;
   endfunction

   function automatic logic [63:0] exp_cout(int k);
      return (m_phase[k] == 2) ? 64'd0 : 64'(view(k, m_cnt[k]));
   endfunction
   function automatic logic [63:0] exp_ovf(int k);
      if (m_phase[k] == 2) return 64'(m_ovfd[k]);
      return (m_cnt[k] > max_of(k)) ? 64'd1 : 64'd0;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   bit          done_seen [N];
   logic [16:0] sb_e;

   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < N; k++) begin
            chk($sformatf("cout_%0d", k),   a_cout[k],        exp_cout(k));
            chk($sformatf("done_%0d", k),   64'(done_w[k]),   64'(m_phase[k] == 2));
            chk($sformatf("ovf_%0d", k),    64'(ovf_w[k]),    exp_ovf(k));
            chk($sformatf("result_%0d", k), a_res[k],         64'(m_res[k]));
            if (done_w[k] === 1'b1 && !done_seen[k]) begin
               if (exp_q[k].size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_%0d: done rose with no window queued @%0t", k, $time);
               end else begin
                  sb_e = exp_q[k].pop_front();
                  chk($sformatf("sb_result_%0d", k), a_res[k],      64'(sb_e[15:0]));
                  chk($sformatf("sb_ovf_%0d", k),    64'(ovf_w[k]), 64'(sb_e[16]));
               end
            end
            done_seen[k] = (done_w[k] === 1'b1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input bit mk, input bit cu, input bit rd, input bit sc);
      mark     = mk;
      cnt_up   = cu;
      rst_done = rd;
      soft_clr = sc;
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic evs(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic async_reset(input bit check);
      mark = 1'b0; cnt_up = 1'b0; rst_done = 1'b0; soft_clr = 1'b0;
      #2;
      rst = 1'b0;
      model_hard_reset();
      #1;
      if (check) begin
         chk("async_cout0", a_cout[0], 64'd0);
         chk("async_done0", 64'(done_w[0]), 64'd0);
         chk("async_result0", a_res[0], 64'd0);
         chk("async_ovf1", 64'(ovf_w[1]), 64'd0);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0; mark = 1'b0; cnt_up = 1'b0; rst_done = 1'b0; soft_clr = 1'b0;
      model_hard_reset();
      @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      rst = 1'b1;

      // align then measure 7 events
      evs(5);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t1_cout_after_align", a_cout[0], 64'd0);
      evs(7);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t1_done", 64'(done_w[0]), 64'd1);
      chk("t1_result", a_res[0], 64'd7);
      chk("t1_edge_result", a_res[3], 64'd1);

      // closed window ignores events and markers until acknowledged
      evs(3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t2_done_held", 64'(done_w[0]), 64'd1);
      chk("t2_result_held", a_res[0], 64'd7);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("t2_done_cleared", 64'(done_w[0]), 64'd0);
      evs(4);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t2_result", a_res[0], 64'd4);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);

      // overflow: 17 events into 4-bit counters
      evs(17);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_sat_result", a_res[1], 64'd15);
      chk("t3_sat_ovf", 64'(ovf_w[1]), 64'd1);
      chk("t3_wrap_result", a_res[2], 64'd1);
      chk("t3_wrap_ovf", 64'(ovf_w[2]), 64'd1);
      chk("t3_wide_result", a_res[0], 64'd17);
      chk("t3_wide_ovf", 64'(ovf_w[0]), 64'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);

      // edge mode: long high then three short pulses
      evs(10);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t4_edge_result", a_res[3], 64'd4);
      chk("t4_level_result", a_res[0], 64'd13);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);

      // async reset mid-window, then the next marker only aligns
      evs(9);
      chk("t5_cout_before", a_cout[0], 64'd9);
      async_reset(1'b1);
      evs(3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5_realign_done", 64'(done_w[0]), 64'd0);
      chk("t5_realign_cout", a_cout[0], 64'd0);

      // marker and event together; soft_clr beats marker
      evs(6);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_result", a_res[0], 64'd7);
      chk("t6_cout", a_cout[0], 64'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("t6_softclr_done", 64'(done_w[0]), 64'd0);
      chk("t6_softclr_result", a_res[0], 64'd0);
      evs(2);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t6_realign_done", 64'(done_w[0]), 64'd0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) async_reset(1'b0);
         else cyc($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      mon_en = 1'b0;
      for (int k = 0; k < N; k++)
         chk($sformatf("sb_drained_%0d", k), 64'(exp_q[k].size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
